// File: rtl/adc_ser_pkg.sv
// +--------------------------------------------------------------------+
// | adc_ser_pkg: shared types and defaults for the ADC word serializer |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package adc_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } ser_state_e;

  localparam int DEFAULT_DATA_W  = 8;
  localparam int DEFAULT_CLK_DIV = 4;

  // Number of cycles during which ser_en is high for one word.
  function automatic int frame_len(input int data_w, input int clk_div, input bit parity_en);
    return (data_w + (parity_en ? 1 : 0)) * clk_div;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_ser_bit_timer.sv
// +--------------------------------------------------------------------+
// | adc_ser_bit_timer: CLK_DIV cycle divider marking serial bit bounds |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module adc_ser_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_start,
  output logic bit_end
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt_q;
  logic [7:0] div_cnt_d;

  always_comb begin
    bit_start = run && (div_cnt_q == 8'd0);
    bit_end   = run && (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q + 8'd1;
    // Idle time keeps the divider parked at zero so every bit starts aligned.
    if (!run || bit_end) begin
      div_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= 8'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_word_serializer.sv
// +--------------------------------------------------------------------+
// | adc_word_serializer: valid/ready ADC word to MSB-first serial line |
// | Optional even parity bit: define ADC_SER_PARITY_EN                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module adc_word_serializer
  import adc_ser_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              adc_ready,
  output logic              ser_out,
  output logic              ser_en,
  output logic              ser_strobe,
  output logic              done
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 255 || DATA_W < 2 || DATA_W > 16) begin : g_bad_param
      $error("adc_word_serializer: DATA_W or CLK_DIV out of range");
    end
  endgenerate

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              run;
  logic              bit_start;
  logic              bit_end;
`ifdef ADC_SER_PARITY_EN
  logic              parity_q, parity_d;

  assign run = (state_q == SHIFT) || (state_q == PARITY);
`else
  assign run = (state_q == SHIFT);
`endif

  adc_ser_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .bit_start(bit_start),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
`ifdef ADC_SER_PARITY_EN
    parity_d   = parity_q;
`endif
    adc_ready  = 1'b0;
    ser_out    = 1'b0;
    ser_en     = 1'b0;
    ser_strobe = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is withheld during reset so no word is taken while rst is high.
        adc_ready = ~rst;
        if (adc_valid && !rst) begin
          state_d   = SHIFT;
          shift_d   = adc_data;
          bit_cnt_d = LAST_BIT;
`ifdef ADC_SER_PARITY_EN
          parity_d  = ^adc_data;
`endif
        end
      end
      SHIFT: begin
        ser_en     = 1'b1;
        ser_out    = shift_q[DATA_W-1];
        ser_strobe = bit_start;
        if (bit_end) begin
          if (bit_cnt_q == '0) begin
`ifdef ADC_SER_PARITY_EN
            state_d = PARITY;
`else
            state_d = DONE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            shift_d   = shift_q << 1;
          end
        end
      end
`ifdef ADC_SER_PARITY_EN
      PARITY: begin
        ser_en     = 1'b1;
        ser_out    = parity_q;
        ser_strobe = bit_start;
        if (bit_end) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef ADC_SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef ADC_SER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_word_serializer.sv
// +--------------------------------------------------------------------+
// | tb_adc_word_serializer: two serializers (CLK_DIV 4 and 1) on one   |
// | random input stream, checked against a cycle-offset frame model    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_adc_word_serializer;
  import adc_ser_pkg::*;

  localparam int DW   = 8;
  localparam int DIV0 = 4;
  localparam int DIV1 = 1;
`ifdef ADC_SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // Extra frame cycles contributed by the parity bit on each instance.
  localparam int PX0 = PAR ? DIV0 : 0;
  localparam int PX1 = PAR ? DIV1 : 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          adc_valid;
  logic [DW-1:0] adc_data;
  logic          rdy0, out0, en0, stb0, dn0;
  logic          rdy1, out1, en1, stb1, dn1;
  logic [4:0]    obs0, obs1;

  always #5 clk = ~clk;

  adc_word_serializer #(.DATA_W(DW), .CLK_DIV(DIV0)) u_dut_div4 (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .adc_ready(rdy0), .ser_out(out0), .ser_en(en0), .ser_strobe(stb0), .done(dn0)
  );

  adc_word_serializer #(.DATA_W(DW), .CLK_DIV(DIV1)) u_dut_div1 (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .adc_ready(rdy1), .ser_out(out1), .ser_en(en1), .ser_strobe(stb1), .done(dn1)
  );

  // {ready, ser_out, ser_en, strobe, done}
  assign obs0 = {rdy0, out0, en0, stb0, dn0};
  assign obs1 = {rdy1, out1, en1, stb1, dn1};

  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            divs [2] = '{DIV0, DIV1};
  bit            m_act [2] = '{1'b0, 1'b0};
  int            m_k [2] = '{0, 0};
  logic [DW-1:0] m_w [2];
  int            pin_r = -1000, pin_a = -1000, pin_s = -1000, pin_c = -1000, pin_b = -1000;
  logic [4:0]    e_v, g_v;

  function automatic bit exp_ready(input int i, input int c);
    return !rst && (!m_act[i] || (c - m_k[i]) >= frame_len(DW, divs[i], PAR) + 2);
  endfunction

  // Outputs follow from the offset of cycle c to the last acceptance edge.
  function automatic logic [4:0] exp_out(input int i, input int c);
    int   t, len, idx;
    logic o, en, stb, dn;
    len = frame_len(DW, divs[i], PAR);
    t   = c - m_k[i];
    en  = m_act[i] && t >= 1 && t <= len;
    o   = 1'b0;
    stb = 1'b0;
    if (en) begin
      idx = (t - 1) / divs[i];
      o   = (idx < DW) ? m_w[i][DW-1-idx] : ^m_w[i];
      stb = ((t - 1) % divs[i]) == 0;
    end
    dn = m_act[i] && t == len + 1;
    return {exp_ready(i, c), o, en, stb, dn};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
      end else if (adc_valid && exp_ready(i, cyc)) begin
        m_act[i] = 1'b1;
        m_k[i]   = cyc;
        m_w[i]   = adc_data;
      end
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic got, input logic exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      e_v   = exp_out(i, cyc);
      g_v   = (i == 0) ? obs0 : obs1;
      n_cmp = n_cmp + 1;
      if (g_v !== e_v) begin
        n_bad = n_bad + 1;
        $display("FAIL model dut%0d cycle %0d {rdy,out,en,stb,done}: got %b expected %b",
                 i, cyc, g_v, e_v);
      end
    end

    case (cyc - pin_r)
      -1: begin
        chk("in_rst_ready_d4", rdy0, 1'b0); chk("in_rst_en_d4", en0, 1'b0);
        chk("in_rst_ready_d1", rdy1, 1'b0);
      end
      0: begin chk("post_rst_ready_d4", rdy0, 1'b1); chk("post_rst_ready_d1", rdy1, 1'b1); end
      default: ;
    endcase

    case (cyc - pin_a)
      1: begin chk("a5_t1_en", en0, 1'b1); chk("a5_t1_out", out0, 1'b1); chk("a5_t1_stb", stb0, 1'b1); end
      2: chk("a5_t2_stb", stb0, 1'b0);
      5: begin chk("a5_t5_out", out0, 1'b0); chk("a5_t5_stb", stb0, 1'b1); end
      9: chk("a5_t9_out", out0, 1'b1);
      29: begin chk("a5_t29_stb", stb0, 1'b1); chk("a5_t29_out", out0, 1'b1); end
      32: begin chk("a5_t32_en", en0, 1'b1); chk("a5_t32_out", out0, 1'b1); end
      33 + PX0: begin chk("a5_done", dn0, 1'b1); chk("a5_done_en", en0, 1'b0); end
      34 + PX0: chk("a5_ready_again", rdy0, 1'b1);
      default: ;
    endcase
    case (cyc - pin_a)
      8: begin chk("a5_d1_t8_stb", stb1, 1'b1); chk("a5_d1_t8_out", out1, 1'b1); end
      9 + PX1: chk("a5_d1_done", dn1, 1'b1);
      default: ;
    endcase

    case (cyc - pin_s)
      1: chk("3c_t1_out", out0, 1'b0);
      9: chk("3c_t9_out", out0, 1'b1);
      21: chk("3c_t21_out", out0, 1'b1);
      25: chk("3c_t25_out", out0, 1'b0);
      35 + PX0: chk("3c_single_word", en0, 1'b0);
      default: ;
    endcase

    case (cyc - pin_c)
      10: chk("abort_t10_en", en0, 1'b1);
      11: begin chk("abort_t11_en", en0, 1'b0); chk("abort_t11_out", out0, 1'b0); chk("abort_t11_ready", rdy0, 1'b1); end
      33 + PX0: chk("abort_no_done", dn0, 1'b0);
      default: ;
    endcase
    case (cyc - pin_c)
      3: chk("div1_t3_stb", stb1, 1'b1);
      6: chk("div1_t6_stb", stb1, 1'b1);
      9 + PX1: chk("div1_done", dn1, 1'b1);
      default: ;
    endcase

    case (cyc - pin_b)
      33 + PX0: chk("b2b_done", dn0, 1'b1);
      34 + PX0: begin chk("b2b_gap_en", en0, 1'b0); chk("b2b_gap_ready", rdy0, 1'b1); end
      35 + PX0: begin chk("b2b_2nd_en", en0, 1'b1); chk("b2b_2nd_stb", stb0, 1'b1); chk("b2b_2nd_msb", out0, 1'b1); end
      default: ;
    endcase
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    adc_valid = 1'b1;
    adc_data  = 8'hFF;
    repeat (3) step();
    rst       = 1'b0;
    adc_valid = 1'b0;
    pin_r     = cyc;
    repeat (2) step();

    adc_valid = 1'b1; adc_data = 8'hA5; pin_a = cyc;
    step();
    adc_valid = 1'b0;
    repeat (45) begin adc_data = 8'($urandom); step(); end

    adc_valid = 1'b1; adc_data = 8'h3C; pin_s = cyc;
    step();
    adc_data = 8'hC3;
    repeat (20) step();
    adc_valid = 1'b0;
    repeat (30) step();

    adc_valid = 1'b1; adc_data = 8'hFF; pin_c = cyc;
    step();
    adc_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (40) step();

    adc_valid = 1'b1; adc_data = 8'h01; pin_b = cyc;
    step();
    adc_data = 8'h80;
    repeat (75) step();
    adc_valid = 1'b0;
    repeat (50) step();

    repeat (3000) begin
      rst       = ($urandom_range(0, 299) == 0);
      adc_valid = ($urandom_range(0, 3) != 0);
      adc_data  = 8'($urandom);
      step();
    end
    rst       = 1'b0;
    adc_valid = 1'b0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
